// File: rtl/tdc_top.sv
// Time-to-digital capture: per-frame coarse timestamp of the first hit,
// stored in a 4-entry result memory and streamed out serially on pin_out.
module tdc_top (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       clkEvent,
  input  logic       clk100_90,
  input  logic       pin_in,
  input  logic       ena,
  input  logic [1:0] addrb,
  output logic       pin_out
);

  // Synchronizer stages: [0] first flop, [1] second flop, [2] edge-detect history
  logic [2:0]  evt_sync;
  logic [2:0]  hit_sync;
  logic [1:0]  ph_sync;

  logic        evt_rise;
  logic        hit_rise;
  logic        fine;

  logic [11:0] coarse;
  logic        half;
  logic        ovf;
  logic [1:0]  frame_id;
  logic [1:0]  fid_inc;
  logic        armed;
  logic [1:0]  wptr;
  logic        capture;
  logic [15:0] wr_word;

  logic [15:0] mem [4];

  logic [4:0]  bit_cnt;
  logic [15:0] shreg;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      evt_sync <= '0;
      hit_sync <= '0;
      ph_sync  <= '0;
    end else begin
      evt_sync <= {evt_sync[1:0], clkEvent};
      hit_sync <= {hit_sync[1:0], pin_in};
      ph_sync  <= {ph_sync[0], clk100_90};
    end
  end

  assign evt_rise = evt_sync[1] & ~evt_sync[2];
  assign hit_rise = hit_sync[1] & ~hit_sync[2];
  assign fine     = ph_sync[1];
  assign ovf      = &coarse;
  assign fid_inc  = frame_id + 2'd1;

  // A hit coinciding with a frame start is stamped as the first instant
  // of the new frame rather than the tail of the old one.
  always_comb begin
    capture = hit_rise & ena & (armed | evt_rise);
    if (evt_rise) begin
      wr_word = {fid_inc, 1'b0, 12'd0, fine};
    end else begin
      wr_word = {frame_id, ovf, coarse, fine};
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      coarse   <= '0;
      half     <= 1'b0;
      frame_id <= '0;
      armed    <= 1'b0;
    end else begin
      if (evt_rise) begin
        coarse   <= '0;
        half     <= 1'b0;
        frame_id <= fid_inc;
      end else begin
        half <= ~half;
        if (half && !ovf) begin
          coarse <= coarse + 12'd1;
        end
      end
      if (capture) begin
        armed <= 1'b0;
      end else if (evt_rise) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else if (capture) begin
      mem[wptr] <= wr_word;
      wptr      <= wptr + 2'd1;
    end
  end

  // Serializer: count 0 is the start bit and the load slot; a same-cycle
  // memory write lands after the load, so the old word is sent.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      pin_out <= 1'b0;
    end else if (bit_cnt == 5'd0) begin
      shreg   <= mem[addrb];
      pin_out <= 1'b1;
      bit_cnt <= 5'd1;
    end else begin
      pin_out <= shreg[15];
      shreg   <= {shreg[14:0], 1'b0};
      bit_cnt <= (bit_cnt == 5'd16) ? 5'd0 : bit_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_tdc_top.sv
// Directed bench for tdc_top: drives frames and hits, keeps a reference
// model of the result memory, and reads entries back through pin_out.
module tb_tdc_top;

  logic       clk100 = 1'b0;
  logic       rst_n = 1'b0;
  logic       clkEvent = 1'b0;
  logic       clk100_90 = 1'b0;
  logic       pin_in = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] addrb = 2'd0;
  logic       pin_out;

  int total = 0;
  int passes = 0;
  int fails = 0;

  logic [16:0] exp_q[$];
  logic [15:0] m_mem [4];
  logic [1:0]  m_wptr;
  logic [1:0]  m_fid;
  int          ser_ph;

  tdc_top dut (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .clkEvent  (clkEvent),
    .clk100_90 (clk100_90),
    .pin_in    (pin_in),
    .ena       (ena),
    .addrb     (addrb),
    .pin_out   (pin_out)
  );

  // clock / reset
  always #5 clk100 = ~clk100;

  // 0 means the next rising edge is a serializer start-bit/load edge
  always @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) ser_ph <= 0;
    else        ser_ph <= (ser_ph == 16) ? 0 : ser_ph + 1;
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 16'h0000;
    m_wptr = 2'd0;
    m_fid  = 2'd0;
  endtask

  // driver: frame start, then a hit j cycles later (same synchronizer latency)
  task automatic frame_with_hit(input int j, input bit en, input bit fv);
    logic [11:0] co;
    int          q;
    ena       = en;
    clk100_90 = fv;
    m_fid     = m_fid + 2'd1;
    q  = (j == 0) ? 0 : (j - 1) / 2;
    co = (q > 4095) ? 12'hFFF : 12'(q);
    for (int c = 0; c <= j + 6; c++) begin
      if (c == 0)     clkEvent = 1'b1;
      if (c == 2)     clkEvent = 1'b0;
      if (c == j)     pin_in   = 1'b1;
      if (c == j + 2) pin_in   = 1'b0;
      tick();
    end
    if (en) begin
      m_mem[m_wptr] = {m_fid, (co == 12'hFFF), co, fv};
      m_wptr        = m_wptr + 2'd1;
    end
  endtask

  task automatic extra_hit();
    pin_in = 1'b1;
    repeat (2) tick();
    pin_in = 1'b0;
    repeat (6) tick();
  endtask

  // scoreboard: push expected stream at request, pop when the word has arrived
  task automatic read_entry(input string tag, input logic [1:0] a, input bit mid_change);
    logic [16:0] got;
    logic [16:0] e;
    exp_q.push_back({1'b1, m_mem[a]});
    for (int k = 0; k < 17 && ser_ph != 0; k++) tick();
    addrb = a;
    for (int b = 16; b >= 0; b--) begin
      tick();
      got[b] = pin_out;
      if (mid_change && b == 8) addrb = ~a;
    end
    e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check("reset_pin_out", 17'(pin_out), 17'd0);
    #2 rst_n = 1'b1;
    tick();
    check("first_start_bit", 17'(pin_out), 17'd1);

    // hit before any frame start must not be stored
    ena    = 1'b1;
    pin_in = 1'b1;
    repeat (2) tick();
    pin_in = 1'b0;
    repeat (6) tick();
    for (int a = 0; a < 4; a++) read_entry("prefrm_mem", 2'(a), 1'b0);

    frame_with_hit(7, 1'b1, 1'b1);
    read_entry("basic_hit_e0", 2'd0, 1'b0);

    frame_with_hit(5, 1'b1, 1'b0);
    extra_hit();
    frame_with_hit(10, 1'b1, 1'b1);
    read_entry("first_hit_only_e1", 2'd1, 1'b0);
    read_entry("ptr_step_e2", 2'd2, 1'b0);
    read_entry("ptr_step_e3_empty", 2'd3, 1'b0);

    frame_with_hit(4, 1'b0, 1'b1);
    read_entry("ena_off_e3", 2'd3, 1'b0);
    frame_with_hit(0, 1'b1, 1'b1);
    read_entry("same_cycle_e3", 2'd3, 1'b0);

    frame_with_hit(8200, 1'b1, 1'b0);
    read_entry("ovf_e0", 2'd0, 1'b0);
    read_entry("addrb_midword_e1", 2'd1, 1'b1);

    // reset in the middle of a serialized word
    for (int k = 0; k < 17 && ser_ph != 0; k++) tick();
    addrb = 2'd0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1 check("reset_async_pin_out", 17'(pin_out), 17'd0);
    repeat (2) tick();
    check("reset_hold_pin_out", 17'(pin_out), 17'd0);
    #2 rst_n = 1'b1;
    model_reset();
    for (int a = 0; a < 4; a++) read_entry("post_reset_mem", 2'(a), 1'b0);

    for (int i = 0; i < 5; i++) frame_with_hit(3 + 2 * i, 1'b1, bit'(i % 2));
    for (int a = 0; a < 4; a++) read_entry("wrap_mem", 2'(a), 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
